// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: gathers per-lane operand beats into packed ALU vectors,
// waits a fixed ALU latency, captures the result vector and streams it out
// one byte per lane.
module vector_alu_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned N_LANES = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic [2:0]                   in_op,
  output logic [WIDTH*N_LANES-1:0]     alu_a,
  output logic [WIDTH*N_LANES-1:0]     alu_b,
  output logic [2:0]                   alu_select,
  input  logic [8*N_LANES-1:0]         alu_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic [$clog2(N_LANES)-1:0]   out_lane,
  output logic                         out_last,
  output logic                         busy
);

  localparam int unsigned LW = $clog2(N_LANES);
  localparam int unsigned VW = WIDTH * N_LANES;
  localparam int unsigned RW = 8 * N_LANES;
  localparam logic [LW-1:0] LAST_LANE = LW'(N_LANES - 1);
  localparam logic [3:0]    WAIT_INIT = 4'(ALU_LAT);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [LW-1:0]   r_lane_cnt;
  logic [3:0]      r_wait_cnt;
  logic [LW-1:0]   r_out_lane;
  logic [VW-1:0]   r_a;
  logic [VW-1:0]   r_b;
  logic [2:0]      r_sel;
  logic [RW-1:0]   r_result;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_out_last;

  logic            w_in_fire;
  logic            w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Sequencer FSM: operand gather, ALU latency wait, per-lane result drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_lane_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_out_lane  <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= '0;
      r_result    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_a[r_lane_cnt*WIDTH +: WIDTH] <= in_a;
            r_b[r_lane_cnt*WIDTH +: WIDTH] <= in_b;
            if (r_lane_cnt == '0) begin
              r_sel <= in_op;
            end
            if (r_lane_cnt == LAST_LANE) begin
              r_state    <= S_WAIT;
              r_lane_cnt <= '0;
              r_wait_cnt <= WAIT_INIT;
              r_in_ready <= 1'b0;
            end else begin
              r_lane_cnt <= r_lane_cnt + LW'(1);
            end
          end
        end

        S_WAIT: begin
          if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end else begin
            r_result    <= alu_result;
            r_state     <= S_DRAIN;
            r_out_valid <= 1'b1;
            r_out_lane  <= '0;
            r_out_last  <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (w_out_fire) begin
            if (r_out_last) begin
              r_state     <= S_LOAD;
              r_out_valid <= 1'b0;
              r_out_lane  <= '0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_out_lane <= r_out_lane + LW'(1);
              r_out_last <= ((r_out_lane + LW'(1)) == LAST_LANE);
            end
          end
        end

        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_select = r_sel;
  assign out_valid  = r_out_valid;
  assign out_lane   = r_out_lane;
  assign out_last   = r_out_last;
  assign out_data   = r_result[r_out_lane*8 +: 8];
  assign busy       = (r_state != S_LOAD) || (r_lane_cnt != '0);

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Testbench for vector_alu_sequencer: table of vectors (fixed + random) against
// a lane-sum ALU model, plus hand sequences for stalls, resets and latency.
module tb_vector_alu_sequencer;

  localparam int NL = 4;
  localparam int W  = 4;

  logic clk;
  logic rst;

  // ---- DUT with ALU_LAT = 1 ----
  logic            in_valid, in_ready;
  logic [W-1:0]    in_a, in_b;
  logic [2:0]      in_op;
  logic [15:0]     alu_a, alu_b;
  logic [2:0]      alu_select;
  logic [31:0]     alu_result, p1;
  logic            out_valid, out_ready, out_last, busy;
  logic [7:0]      out_data;
  logic [1:0]      out_lane;

  // ---- DUT with ALU_LAT = 3 ----
  logic            in_valid3, in_ready3;
  logic [W-1:0]    in_a3, in_b3;
  logic [2:0]      in_op3;
  logic [15:0]     alu_a3, alu_b3;
  logic [2:0]      alu_sel3;
  logic [31:0]     alu_res3, p3_0, p3_1, p3_2;
  logic            out_valid3, out_ready3, out_last3, busy3;
  logic [7:0]      out_data3;
  logic [1:0]      out_lane3;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a_vec;
    logic [15:0] b_vec;
    logic [2:0]  op;
    logic        bubbles;
    int          stall_lane;
    int          stall_n;
    logic [31:0] exp_out;
  } vec_t;

  vec_t t[8];

  // Reference ALU behaviour: each lane byte is the 8-bit sum of its operands.
  function automatic logic [31:0] lane_sums(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[i*8 +: 8] = 8'(a[i*W +: W]) + 8'(b[i*W +: W]);
    return r;
  endfunction

  vector_alu_sequencer #(.WIDTH(W), .N_LANES(NL), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_select(alu_select), .alu_result(alu_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
    .out_last(out_last), .busy(busy)
  );

  vector_alu_sequencer #(.WIDTH(W), .N_LANES(NL), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_a(in_a3), .in_b(in_b3), .in_op(in_op3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_select(alu_sel3), .alu_result(alu_res3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .out_lane(out_lane3),
    .out_last(out_last3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipelined ALU models; output is scrambled once a result is draining so a
  // sequencer that keeps sampling alu_result is caught.
  always @(posedge clk) begin
    p1   <= lane_sums(alu_a, alu_b);
    p3_0 <= lane_sums(alu_a3, alu_b3);
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign alu_result = p1   ^ (out_valid  ? 32'hA5A5A5A5 : 32'h0);
  assign alu_res3   = p3_2 ^ (out_valid3 ? 32'h5A5A5A5A : 32'h0);

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_wait(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  task automatic wait_out();
    int c;
    c = 0;
    while (!out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) fail_wait("out_valid_wait");
  endtask

  // Drive the four operand beats of a vector, optionally with idle bubbles.
  task automatic send_vec(input vec_t v);
    int c;
    for (int l = 0; l < NL; l++) begin
      @(negedge clk);
      if (v.bubbles) begin
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_a     = v.a_vec[l*W +: W];
      in_b     = v.b_vec[l*W +: W];
      in_op    = (l == 0) ? v.op : ~v.op;
      c = 0;
      while (!in_ready && c < 50) begin
        @(negedge clk);
        c++;
      end
      if (c >= 50) fail_wait("in_ready_wait");
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Collect the four result beats, optionally stalling on one lane.
  task automatic recv_vec(input vec_t v);
    for (int l = 0; l < NL; l++) begin
      if (l == v.stall_lane) begin
        for (int s = 0; s < v.stall_n; s++) begin
          @(negedge clk);
          out_ready = 1'b0;
          wait_out();
          chk("stall_data", 32'(out_data), 32'(v.exp_out[l*8 +: 8]));
          chk("stall_lane", 32'(out_lane), 32'(l));
        end
      end
      @(negedge clk);
      out_ready = 1'b1;
      wait_out();
      chk("out_data", 32'(out_data), 32'(v.exp_out[l*8 +: 8]));
      chk("out_lane", 32'(out_lane), 32'(l));
      chk("out_last", 32'(out_last), (l == NL-1) ? 32'd1 : 32'd0);
      if (l == 0) begin
        chk("alu_select", 32'(alu_select), 32'(v.op));
        chk("alu_a", 32'(alu_a), 32'(v.a_vec));
        chk("alu_b", 32'(alu_b), 32'(v.b_vec));
        chk("in_ready_drain", 32'(in_ready), 32'd0);
        chk("busy_drain", 32'(busy), 32'd1);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    logic [15:0] va3, vb3;
    logic [31:0] exp3;
    int n0, c;
    bit done;

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; in_op3 = '0; out_ready3 = 1'b0;

    t[0] = '{16'h4321, 16'h8765, 3'd0, 1'b0, -1, 0, 32'h0C0A0806};
    t[1] = '{16'h4321, 16'h8765, 3'd0, 1'b0,  2, 3, 32'h0C0A0806};
    t[2] = '{16'h4321, 16'h8765, 3'd5, 1'b1, -1, 0, 32'h0C0A0806};
    for (int i = 3; i < 8; i++) begin
      t[i].a_vec      = 16'($urandom);
      t[i].b_vec      = 16'($urandom);
      t[i].op         = 3'($urandom_range(0, 7));
      t[i].bubbles    = 1'($urandom_range(0, 1));
      t[i].stall_lane = $urandom_range(0, 3);
      t[i].stall_n    = $urandom_range(0, 3);
      t[i].exp_out    = lane_sums(t[i].a_vec, t[i].b_vec);
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_select", 32'(alu_select), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      send_vec(t[i]);
      recv_vec(t[i]);
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Back-to-back: in_valid held high through the drain
    send_vec(t[4]);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 4'hF;
    in_b      = 4'hF;
    done = 1'b0;
    for (c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      chk("no_overlap", 32'(in_ready & out_valid), 32'd0);
      if (out_valid && out_last) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    if (!done) fail_wait("b2b_last_wait");
    @(negedge clk);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    chk("b2b_out_valid", 32'(out_valid), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    send_vec(t[5]);
    recv_vec(t[5]);

    // Reset after lane-1 result handshake
    send_vec(t[0]);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wait_out();
      @(posedge clk);
    end
    @(negedge clk);
    chk("pre_rst_lane", 32'(out_lane), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_lane", 32'(out_lane), 32'd0);
    send_vec(t[3]);
    recv_vec(t[3]);

    // Reset mid-LOAD discards the partial vector
    @(negedge clk);
    in_valid = 1'b1; in_a = 4'h7; in_b = 4'h7; in_op = 3'd7;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("partial_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_vec(t[6]);
    recv_vec(t[6]);

    // ALU_LAT = 3: WAIT spans four cycles, result is the delayed model output
    va3  = 16'hF1A9;
    vb3  = 16'h7E3C;
    exp3 = 32'h160F0D15;
    out_ready3 = 1'b0;
    for (int l = 0; l < NL; l++) begin
      @(negedge clk);
      in_valid3 = 1'b1;
      in_a3 = va3[l*W +: W];
      in_b3 = vb3[l*W +: W];
      in_op3 = (l == 0) ? 3'd6 : 3'd1;
      c = 0;
      while (!in_ready3 && c < 50) begin
        @(negedge clk);
        c++;
      end
      if (c >= 50) fail_wait("lat3_in_ready_wait");
      @(posedge clk);
    end
    n0 = 0;
    done = 1'b0;
    for (c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      in_valid3 = 1'b0;
      if (out_valid3) done = 1'b1;
      else n0++;
    end
    chk("lat3_wait_cycles", 32'(n0), 32'd4);
    chk("lat3_alu_select", 32'(alu_sel3), 32'd6);
    out_ready3 = 1'b1;
    for (int l = 0; l < NL; l++) begin
      c = 0;
      while (!out_valid3 && c < 50) begin
        @(negedge clk);
        c++;
      end
      if (c >= 50) fail_wait("lat3_out_valid_wait");
      chk("lat3_out_data", 32'(out_data3), 32'(exp3[l*8 +: 8]));
      chk("lat3_out_lane", 32'(out_lane3), 32'(l));
      chk("lat3_out_last", 32'(out_last3), (l == NL-1) ? 32'd1 : 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("lat3_idle_valid", 32'(out_valid3), 32'd0);
    chk("lat3_idle_ready", 32'(in_ready3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_alu_sequencer.md
VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand bits per lane.
REQ-002 SHALL have parameter N_LANES, default 4, meaning ALU lane count; legal range 2..16.
REQ-003 SHALL have parameter ALU_LAT, default 1, meaning ALU cycles from stable operands to valid result; legal range 0..15.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  operand beat valid.
REQ-008 in_ready  output  1  sequencer accepts an operand beat.
REQ-009 in_a  input  WIDTH  lane operand A.
REQ-010 in_b  input  WIDTH  lane operand B.
REQ-011 in_op  input  3  operation select, sampled on the lane-0 beat only.
REQ-012 alu_a  output  WIDTH*N_LANES  packed A vector; lane i at [i*WIDTH +: WIDTH].
REQ-013 alu_b  output  WIDTH*N_LANES  packed B vector, same packing.
REQ-014 alu_select  output  3  registered operation to the ALU.
REQ-015 alu_result  input  8*N_LANES  ALU result; lane i at [i*8 +: 8].
REQ-016 out_valid  output  1  result beat valid.
REQ-017 out_ready  input  1  downstream accepts a result beat.
REQ-018 out_data  output  8  result byte of lane out_lane.
REQ-019 out_lane  output  $clog2(N_LANES)  lane index of current result beat.
REQ-020 out_last  output  1  high on the lane N_LANES-1 result beat.
REQ-021 busy  output  1  high when state is not LOAD or lane counter is non-zero.

Function
REQ-022 SHALL implement states LOAD, WAIT, DRAIN.
REQ-023 LOAD: in_ready=1; each in_valid&&in_ready writes in_a/in_b into lane lane_cnt of operand registers, then lane_cnt increments.
REQ-024 LOAD: beat with lane_cnt=0 SHALL also register in_op into alu_select; in_op on other beats ignored.
REQ-025 LOAD: cycles with in_valid=0 SHALL not change lane_cnt or operand registers.
REQ-026 LOAD: accepted beat at lane_cnt=N_LANES-1 SHALL move to WAIT, clear lane_cnt, load wait_cnt=ALU_LAT.
REQ-027 WAIT: in_ready=0, out_valid=0; wait_cnt≠0 decrements; wait_cnt=0 captures alu_result into result register and moves to DRAIN (WAIT lasts ALU_LAT+1 cycles).
REQ-028 alu_a, alu_b, alu_select SHALL be driven directly from registers and SHALL hold stable through WAIT and DRAIN.
REQ-029 DRAIN: out_valid=1, out_data=result[out_lane*8 +: 8], out_last=(out_lane==N_LANES-1), in_ready=0.
REQ-030 DRAIN: out_valid&&out_ready increments out_lane; on out_last beat returns to LOAD with out_lane=0.
REQ-031 DRAIN with out_ready=0 SHALL hold out_data, out_lane, out_last unchanged; no beat skipped or repeated.
REQ-032 First operand beat of next vector SHALL be accepted no earlier than the cycle after the out_last handshake.
REQ-033 Result register SHALL change only on WAIT capture; later alu_result changes SHALL not affect out_data.

Reset
REQ-034 rst=1 SHALL immediately force state LOAD, lane_cnt=0, wait_cnt=0, out_lane=0, operand/result registers and alu_select to 0.
REQ-035 While rst=1: in_ready=0, out_valid=0, out_last=0, busy=0, alu_a=0, alu_b=0.
REQ-036 Reset mid-LOAD, WAIT or DRAIN SHALL discard the partial vector; first beat after release is lane 0.

Verification
REQ-037 N=4, W=4, LAT=1, ALU model out_i=a_i+b_i; beats a=1,2,3,4 b=5,6,7,8 op=0 -> alu_a=16'h4321, alu_b=16'h8765, alu_select=0; out 0x06,0x08,0x0A,0x0C lanes 0..3, out_last on 4th only.
REQ-038 Same vector, out_ready low 3 cycles at lane 2 -> out_data holds 0x0A, out_lane=2; sequence completes without loss.
REQ-039 in_valid bubbles between every beat; in_op=5 on lane 0, 2 on lane 1 -> alu_select=5; results equal REQ-037.
REQ-040 ALU_LAT=3 -> WAIT exactly 4 cycles; out_valid rises the cycle after capture; model result delayed 3 cycles is returned correctly.
REQ-041 rst pulse after lane-1 result handshake -> out_valid=0 immediately; after release in_ready=1, next vector loads from lane 0 and drains correctly.
REQ-042 Back-to-back vectors with out_ready=1 and in_valid=1 -> in_ready rises the cycle after out_last handshake; no overlap of LOAD and DRAIN.
